// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: accepts one aligned access at a time, runs a
// request/data handshake on the bus, and returns extended load data.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stallreq,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        in_idle, in_req, in_wait, in_done;
  logic        req_misaligned;
  logic [31:0] load_ext;

  // Size 3 is reserved and behaves as a word everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return lo[0];
      default: return (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    return 4'b0001 << lo;
      2'd1:    return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'd0:    return {4{wd[7:0]}};
      2'd1:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [1:0] size, input logic sign,
                                              input logic [1:0] lo, input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] sx;
    b = rdata[{lo, 3'b000} +: 8];
    h = rdata[{lo[1], 4'b0000} +: 16];
    case (size)
      2'd0: begin
        sx = b;
        return sign ? sx : {24'd0, b};
      end
      2'd1: begin
        sx = h;
        return sign ? sx : {16'd0, h};
      end
      default: return rdata;
    endcase
  endfunction

  assign in_idle        = (state_q == ST_IDLE);
  assign in_req         = (state_q == ST_REQ);
  assign in_wait        = (state_q == ST_WAIT);
  assign in_done        = (state_q == ST_DONE);
  assign req_misaligned = is_misaligned(req_size, req_addr[1:0]);
  assign load_ext       = extend_load(size_q, sign_q, addr_q[1:0], bus_rdata);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sign_d  = sign_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && !req_misaligned) begin
          we_d    = req_we;
          size_d  = req_size;
          sign_d  = req_sign;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // data_ok only counts once the address phase has been accepted.
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            state_d = ST_DONE;
            if (!we_q) rdata_d = load_ext;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus_data_ok) begin
          state_d = ST_DONE;
          if (!we_q) rdata_d = load_ext;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Latched request fields are only observed through REQ-gated outputs.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    size_q  <= size_d;
    sign_q  <= sign_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign stallreq   = ~rst & ((in_idle & req_valid & ~req_misaligned) | in_req | in_wait);
  assign misalign   = ~rst & in_idle & req_valid & req_misaligned;
  assign resp_valid = ~rst & in_done;
  assign resp_rdata = rst ? 32'd0 : rdata_q;

  assign bus_req   = ~rst & in_req;
  assign bus_wr    = bus_req & we_q;
  assign bus_size  = bus_req ? size_q : 2'd0;
  assign bus_addr  = bus_req ? addr_q : 32'd0;
  assign bus_wstrb = (bus_req & we_q) ? byte_strobe(size_q, addr_q[1:0]) : 4'd0;
  assign bus_wdata = bus_req ? replicate_wdata(size_q, wdata_q) : 32'd0;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL use clock clk and reset rst, where rst is synchronous and active-high.
REQ-002 The ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  MEM-stage load/store present
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word; 3 reserved, treated as word
- req_sign  in  1  load sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- stallreq  out  1  pipeline stall request
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data
- misalign  out  1  misaligned-access pulse
- bus_req  out  1  bus request
- bus_wr  out  1  bus write
- bus_size  out  2  bus size
- bus_addr  out  32  bus address
- bus_wstrb  out  4  byte strobes
- bus_wdata  out  32  replicated write data
- bus_addr_ok  in  1  request accepted
- bus_data_ok  in  1  data returned / write done
- bus_rdata  in  32  read data

Function
REQ-003 The FSM SHALL have states IDLE, REQ, WAIT, DONE (2-bit encoding).
REQ-004 Misaligned SHALL mean half with addr[0]=1, or word with addr[1:0]!=0.
REQ-005 IDLE: on req_valid and aligned, the block SHALL latch we, size, sign, addr and wdata, and go to REQ next cycle.
REQ-006 IDLE: on req_valid and misaligned, the block SHALL assert misalign combinationally, SHALL NOT assert stallreq, and SHALL start no bus transaction.
REQ-007 REQ: bus_req=1 with stable latched fields; on bus_addr_ok=0 the block SHALL stay in REQ; on bus_addr_ok=1 and bus_data_ok=0 it SHALL go to WAIT; on bus_addr_ok=1 and bus_data_ok=1 it SHALL go to DONE.
REQ-008 bus_data_ok SHALL be ignored in REQ unless bus_addr_ok=1 in the same cycle.
REQ-009 WAIT: bus_req=0; on bus_data_ok=1 the block SHALL go to DONE and, for loads, capture the extended data into resp_rdata.
REQ-010 DONE: resp_valid=1 for exactly one cycle; next state SHALL be IDLE unconditionally; req_valid in DONE SHALL be ignored, since it is the same instruction that is retiring.
REQ-011 stallreq SHALL equal (IDLE & req_valid & aligned) | REQ | WAIT, and SHALL be 0 in DONE.
REQ-012 Strobes: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-013 Write data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-014 bus_wstrb SHALL be 0 for loads.
REQ-015 Load extraction: byte bus_rdata[8*addr[1:0]+:8]; half bus_rdata[16*addr[1]+:16]; zero- or sign-extended to 32 bits per the latched sign.
REQ-016 resp_rdata SHALL hold its value until the next load capture, and SHALL be left unchanged by stores.
REQ-017 bus_addr SHALL be the full latched address, with bus_size equal to the latched size.
REQ-018 Request latency SHALL be 1 cycle from IDLE acceptance to bus_req.
REQ-019 Minimum transaction SHALL be 3 cycles (IDLE, REQ, DONE) with stallreq high for 2 cycles.

Reset
REQ-020 On rst, the state SHALL go to IDLE and resp_rdata SHALL be 0.
REQ-021 On rst, all outputs SHALL be 0 during and after the reset cycle until a new request.
REQ-022 Reset mid-transaction SHALL abandon it with no resp_valid; a late bus_data_ok arriving in IDLE SHALL be ignored.

Verification
REQ-023 Word load at 0x100 with addr_ok in the 1st REQ cycle and data_ok 2 cycles later, rdata=0xDEADBEEF -> resp_rdata=0xDEADBEEF, stallreq high 4 cycles, resp_valid 1 cycle.
REQ-024 Signed byte load at 0x103 with rdata=0x80112233 -> resp_rdata=0xFFFFFF80; the unsigned variant -> 0x00000080.
REQ-025 Half store at 0x202 with wdata=0x1234ABCD -> bus_wstrb=4'b1100, bus_wdata=0xABCDABCD, bus_wr=1.
REQ-026 Word load at 0x101 -> misalign=1 for one cycle, stallreq=0, bus_req never asserted.
REQ-027 addr_ok and data_ok in the same cycle -> REQ goes directly to DONE; addr_ok held low 5 cycles -> bus_req and fields stable for all 5 cycles.
REQ-028 rst asserted in WAIT, then data_ok the following cycle -> no resp_valid and state remains IDLE.
